burst_pattern_gen: RTL and testbench
====================================

# burst_pattern_gen

Trigger-driven, parametrised burst source that writes a programmable pattern into the Ethernet transmit path (the `i_data`/`i_wr` side of `eth_session`). On each rising edge of a trigger it emits one or more bursts of `i_len` words, with a choice of four data patterns, optional repeats separated by idle gaps, downstream back-pressure, and abort. It succeeds the fixed 10-word incrementing stimulus used to exercise the Ethernet session, and sits between the acquisition/trigger logic and `eth_session` in bring-up and self-test builds.

## Interface
- `DATA_W`, 8: data word width.
- `LEN_W`, 13: burst length counter width.
- `GAP_W`, 8: inter-burst gap counter width.
- `LFSR_TAPS`, 8'hB8: Galois LFSR tap mask, `DATA_W` bits wide (default is maximal-length for 8 bits).
- `i_clk` in 1: the single clock; all logic is on its rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_trig` in 1: trigger level; a burst sequence starts on its rising edge.
- `i_abort` in 1: synchronous abort; returns the block to IDLE.
- `i_len` in `LEN_W`: words per burst; 0 means the trigger is ignored.
- `i_mode` in 2: pattern select. 0 = increment from seed, 1 = constant seed, 2 = LFSR, 3 = walking one.
- `i_seed` in `DATA_W`: pattern start value.
- `i_repeat` in 8: number of additional bursts after the first.
- `i_gap` in `GAP_W`: number of idle cycles between bursts.
- `i_full` in 1: downstream full flag (`eth_session` `o_full`).
- `o_data` out `DATA_W`: write data.
- `o_wr` out 1: write strobe; a word is transferred on every cycle this is high.
- `o_busy` out 1: high while a burst sequence is in progress.
- `o_done` out 1: one-cycle pulse on the final word of the final burst.

## Operation
**States:** IDLE, RUN, GAP.

**Trigger detection**
- Delay register `trig_d` has reset value 1, so a trigger already high at reset release does not fire.
- Start condition: `i_trig & !trig_d` while in IDLE and `i_len != 0`.
- Triggers seen in RUN or GAP are ignored.

**At start**
- `i_len`, `i_mode`, `i_seed`, `i_repeat` and `i_gap` are latched and held for the whole sequence.
- Word counter is cleared and the pattern register is loaded.
- State goes to RUN.

**RUN**
- Each cycle with `i_full = 0`: `o_wr <= 1`, `o_data <=` pattern register, pattern advances, word counter increments.
- Each cycle with `i_full = 1`: `o_wr <= 0`; pattern and counter hold.
- On issuing word `len-1`:
  - If repeats remain and gap is 0: decrement repeats and stay in RUN, so the next burst follows back-to-back.
  - If repeats remain and gap is nonzero: decrement repeats and go to GAP.
  - If no repeats remain: go to IDLE and set `o_done <= 1` on the same edge, so `o_done` is high together with the final `o_wr`.

**GAP**
- `o_wr = 0` for exactly `gap` cycles, then RUN.
- The pattern register reloads at every burst start.

**Pattern load and advance** (all arithmetic modulo 2^`DATA_W`)
- Mode 0: load seed; advance +1, wrapping.
- Mode 1: load seed; hold.
- Mode 2: load seed, or 1 if seed is 0 (avoids lock-up); advance `p = (p>>1) ^ (p[0] ? LFSR_TAPS : 0)`.
- Mode 3: load 1 (seed ignored); advance rotate-left by 1.

**Abort**
- `i_abort` takes priority over everything, including a simultaneous start.
- Next edge: IDLE, `o_wr <= 0`, `o_done` stays 0.

**Reset values:** `o_data` 0, `o_wr` 0, `o_busy` 0, `o_done` 0, `trig_d` 1, state IDLE.

## Timing
- Trigger first sampled high at edge k: state is RUN after edge k, first `o_wr`/`o_data` is valid after edge k+1. Latency is 2 cycles.
- With no back-pressure, a burst is `len` consecutive `o_wr` cycles.
- `i_full` is registered-path back-pressure: `o_wr` drops one cycle after `i_full` rises. The downstream must therefore accept one word after asserting full.
- `o_busy` is high from edge k to the edge that returns to IDLE, so it falls the cycle after the last `o_wr`.
- Gap between bursts: exactly `gap` cycles with `o_wr` low; 0 gives no idle cycle.
- A new trigger is accepted no earlier than the first cycle in which `o_busy` reads 0.

## Test plan
- **Basic burst.** len=10, mode 0, seed 1, repeat 0, `i_full`=0, trigger pulse: `o_wr` high for 10 consecutive cycles starting 2 cycles after the trigger, data 1..10. `o_done` coincides with data 10; `o_busy` low the following cycle.
- **Wrap and length zero.** Mode 0, seed 8'hFE, len 4: data FE, FF, 00, 01. With len=0, a trigger gives no `o_wr` and no `o_busy`.
- **Back-pressure.** len 6, seed 8'h10, `i_full` held high for 3 cycles mid-burst: `o_wr` gaps for 3 cycles starting one cycle after `i_full` rises. Data sequence is 10..15 unbroken; total `o_wr` count is 6.
- **Repeats and gap.** Mode 1, seed 8'hA5, len 3, repeat 2, gap 3: three bursts of A5, A5, A5 separated by exactly 3 idle cycles. Exactly one `o_done`. A second run with gap 0 gives 9 contiguous writes.
- **LFSR and walking one.** Mode 2, seed 0, len 3: 01, B8, 5C. Mode 3, len 9: 01, 02, 04, 08, 10, 20, 40, 80, 01.
- **Control edge cases.**
  - `i_trig` high through reset release: no burst.
  - Re-trigger while busy: ignored, with correct word count.
  - `i_abort` mid-burst: `o_wr` low the next cycle, no `o_done`, and a fresh trigger afterwards starts cleanly from the seed.
  - Asserting `i_rst` mid-burst: all outputs return to 0 immediately.

Source files
------------

// File: rtl/burst_pattern_gen_if.sv
// Signal bundle between the burst source and the Ethernet transmit path.
// Trigger/config inputs, write strobe with full back-pressure, status outputs.
interface burst_pattern_gen_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 13,
    parameter int GAP_W  = 8
);
    logic              i_trig;
    logic              i_abort;
    logic [LEN_W-1:0]  i_len;
    logic [1:0]        i_mode;
    logic [DATA_W-1:0] i_seed;
    logic [7:0]        i_repeat;
    logic [GAP_W-1:0]  i_gap;
    logic              i_full;
    logic [DATA_W-1:0] o_data;
    logic              o_wr;
    logic              o_busy;
    logic              o_done;
    logic [1:0]        o_state;

    // Handshake: o_wr is a push strobe (a word moves on every cycle it is high,
    // there is no ready). i_full is sampled on the clock edge, so o_wr drops one
    // cycle after i_full rises and the sink must absorb one extra word.
    modport master (
        input  i_trig, i_abort, i_len, i_mode, i_seed, i_repeat, i_gap, i_full,
        output o_data, o_wr, o_busy, o_done, o_state
    );
    modport slave (
        output i_trig, i_abort, i_len, i_mode, i_seed, i_repeat, i_gap, i_full,
        input  o_data, o_wr, o_busy, o_done, o_state
    );
endinterface

// File: rtl/burst_pattern_gen.sv
// Trigger-driven burst source: emits repeated bursts of a programmable pattern
// into the Ethernet transmit path, with idle gaps, back-pressure and abort.
module burst_pattern_gen #(
    parameter int                DATA_W    = 8,
    parameter int                LEN_W     = 13,
    parameter int                GAP_W     = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    burst_pattern_gen_if.master bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_GAP = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              trig_q;
    logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d, pat_q, pat_d, data_q, data_d;
    logic [7:0]        rep_q, rep_d;
    logic [GAP_W-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic              wr_q, wr_d, done_q, done_d, busy_q, busy_d;
    logic              start, issue, last;

    function automatic logic [DATA_W-1:0] pat_load(input logic [1:0] mode,
                                                   input logic [DATA_W-1:0] seed);
        case (mode)
            2'd2:    pat_load = (seed == '0) ? DATA_W'(1) : seed;
            2'd3:    pat_load = DATA_W'(1);
            default: pat_load = seed;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] pat_next(input logic [1:0] mode,
                                                   input logic [DATA_W-1:0] p);
        case (mode)
            2'd0:    pat_next = p + DATA_W'(1);
            2'd2:    pat_next = (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
            2'd3:    pat_next = {p[DATA_W-2:0], p[DATA_W-1]};
            default: pat_next = p;
        endcase
    endfunction

    // busy_q still high during the final-word cycle blocks a restart until busy reads 0
    assign start = (state_q == S_IDLE) && !busy_q && bus.i_trig && !trig_q && (bus.i_len != '0);
    assign issue = (state_q == S_RUN) && !bus.i_full;
    assign last  = issue && (cnt_q == len_q - LEN_W'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.i_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start) state_d = S_RUN;
                S_RUN: begin
                    if (last) begin
                        if (rep_q == 8'd0)     state_d = S_IDLE;
                        else if (gap_q != '0)  state_d = S_GAP;
                    end
                end
                S_GAP:   if (gap_cnt_q <= GAP_W'(1)) state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        len_d     = len_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        data_d    = data_q;
        wr_d      = 1'b0;
        done_d    = 1'b0;
        busy_d    = 1'b0;
        if (!bus.i_abort) begin
            busy_d = (state_d != S_IDLE) || last;
            if (start) begin
                len_d  = bus.i_len;
                mode_d = bus.i_mode;
                seed_d = bus.i_seed;
                rep_d  = bus.i_repeat;
                gap_d  = bus.i_gap;
                cnt_d  = '0;
                pat_d  = pat_load(bus.i_mode, bus.i_seed);
            end
            if (issue) begin
                wr_d   = 1'b1;
                data_d = pat_q;
                pat_d  = pat_next(mode_q, pat_q);
                cnt_d  = cnt_q + LEN_W'(1);
                if (last) begin
                    cnt_d = '0;
                    if (rep_q != 8'd0) begin
                        rep_d     = rep_q - 8'd1;
                        gap_cnt_d = gap_q;
                        pat_d     = pat_load(mode_q, seed_q);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            if (state_q == S_GAP) gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            trig_q    <= 1'b1;
            len_q     <= '0;
            mode_q    <= '0;
            seed_q    <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            cnt_q     <= '0;
            pat_q     <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            trig_q    <= bus.i_trig;
            len_q     <= len_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_wr    = wr_q;
    assign bus.o_done  = done_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_state = state_q;
endmodule

// File: tb/tb_burst_pattern_gen.sv
// Directed bench for burst_pattern_gen: hand-computed data streams and
// per-cycle write-strobe masks, checked with immediate assertions.
module tb_burst_pattern_gen;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 13;
    localparam int GAP_W  = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    burst_pattern_gen_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W)) bus ();

    burst_pattern_gen #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W), .LFSR_TAPS(8'hB8)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cfg(input int len, input int mode, input int seed, input int rep, input int gap);
        bus.i_len    = LEN_W'(len);
        bus.i_mode   = 2'(mode);
        bus.i_seed   = DATA_W'(seed);
        bus.i_repeat = 8'(rep);
        bus.i_gap    = GAP_W'(gap);
    endtask

    // Iteration c drives inputs then takes edge c; edge 0 samples the trigger rise.
    task automatic run_stream(input string tag, input int ncyc, input logic [63:0] mask,
                              input int retrig_at, input int full_at, input int full_n,
                              input int abort_at, input bit exp_done);
        int   ndone;
        logic exp_d;
        logic [DATA_W-1:0] e;
        ndone = 0;
        for (int c = 0; c < ncyc; c++) begin
            bus.i_trig  = (c == 0) || (c == retrig_at);
            bus.i_full  = (c >= full_at) && (c < full_at + full_n);
            bus.i_abort = (c == abort_at);
            tick();
            chk({tag, " wr"}, 32'(bus.o_wr), 32'(mask[c]));
            exp_d = 1'b0;
            if (bus.o_wr === 1'b1) begin
                chk({tag, " busy_with_wr"}, 32'(bus.o_busy), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk({tag, " data"}, 32'(bus.o_data), 32'(e));
                end
                exp_d = exp_done && (exp_q.size() == 0);
            end
            chk({tag, " done"}, 32'(bus.o_done), 32'(exp_d));
            if (bus.o_done === 1'b1) ndone++;
        end
        bus.i_trig  = 1'b0;
        bus.i_full  = 1'b0;
        bus.i_abort = 1'b0;
        chk({tag, " words_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, " done_count"}, 32'(ndone), 32'(exp_done));
        chk({tag, " busy_end"}, 32'(bus.o_busy), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.i_trig = 1'b1;
        bus.i_abort = 1'b0;
        bus.i_full = 1'b0;
        cfg(10, 0, 1, 0, 0);
        tick();
        tick();
        chk("reset data", 32'(bus.o_data), 32'd0);
        chk("reset wr", 32'(bus.o_wr), 32'd0);
        chk("reset busy", 32'(bus.o_busy), 32'd0);
        chk("reset done", 32'(bus.o_done), 32'd0);

        // trigger held high through reset release must not fire
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("trig_at_reset wr", 32'(bus.o_wr), 32'd0);
            chk("trig_at_reset busy", 32'(bus.o_busy), 32'd0);
        end
        bus.i_trig = 1'b0;
        tick();
        tick();

        cfg(10, 0, 1, 0, 0);
        for (int i = 1; i <= 10; i++) exp_q.push_back(DATA_W'(i));
        run_stream("basic", 13, 64'h7FE, -1, -1, 0, -1, 1'b1);

        cfg(4, 0, 8'hFE, 0, 0);
        exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        run_stream("wrap", 7, 64'h1E, -1, -1, 0, -1, 1'b1);

        cfg(0, 0, 8'h33, 0, 0);
        bus.i_trig = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.i_trig = 1'b0;
            chk("len0 wr", 32'(bus.o_wr), 32'd0);
            chk("len0 busy", 32'(bus.o_busy), 32'd0);
        end
        tick();

        cfg(6, 0, 8'h10, 0, 0);
        for (int i = 0; i < 6; i++) exp_q.push_back(DATA_W'(8'h10 + i));
        run_stream("backpressure", 12, 64'h3C6, -1, 3, 3, -1, 1'b1);

        cfg(3, 1, 8'hA5, 2, 3);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'hA5);
        run_stream("rep_gap3", 18, 64'hE38E, -1, -1, 0, -1, 1'b1);

        cfg(3, 1, 8'hA5, 2, 0);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'hA5);
        run_stream("rep_gap0", 12, 64'h3FE, -1, -1, 0, -1, 1'b1);

        cfg(3, 2, 8'h00, 0, 0);
        exp_q.push_back(8'h01); exp_q.push_back(8'hB8); exp_q.push_back(8'h5C);
        run_stream("lfsr", 6, 64'hE, -1, -1, 0, -1, 1'b1);

        cfg(9, 3, 8'h55, 0, 0);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
        exp_q.push_back(8'h08); exp_q.push_back(8'h10); exp_q.push_back(8'h20);
        exp_q.push_back(8'h40); exp_q.push_back(8'h80); exp_q.push_back(8'h01);
        run_stream("walk1", 12, 64'h3FE, -1, -1, 0, -1, 1'b1);

        cfg(5, 0, 8'h20, 0, 0);
        for (int i = 0; i < 5; i++) exp_q.push_back(DATA_W'(8'h20 + i));
        run_stream("retrig_mid", 10, 64'h3E, 3, -1, 0, -1, 1'b1);

        // re-trigger rising on the edge right after the final word, while busy still reads 1
        for (int i = 0; i < 5; i++) exp_q.push_back(DATA_W'(8'h20 + i));
        run_stream("retrig_tail", 10, 64'h3E, 6, -1, 0, -1, 1'b1);

        cfg(8, 0, 8'h40, 0, 0);
        exp_q.push_back(8'h40); exp_q.push_back(8'h41); exp_q.push_back(8'h42);
        run_stream("abort_mid", 8, 64'hE, -1, -1, 0, 4, 1'b0);

        for (int i = 0; i < 8; i++) exp_q.push_back(DATA_W'(8'h40 + i));
        run_stream("after_abort", 11, 64'h1FE, -1, -1, 0, -1, 1'b1);

        run_stream("abort_at_start", 5, 64'h0, -1, -1, 0, 0, 1'b0);

        cfg(8, 0, 8'h60, 0, 0);
        bus.i_trig = 1'b1;
        tick();
        bus.i_trig = 1'b0;
        tick();
        tick();
        chk("rst_mid pre wr", 32'(bus.o_wr), 32'd1);
        chk("rst_mid pre data", 32'(bus.o_data), 32'h61);
        rst = 1'b1;
        #1;
        chk("rst_mid data", 32'(bus.o_data), 32'd0);
        chk("rst_mid wr", 32'(bus.o_wr), 32'd0);
        chk("rst_mid busy", 32'(bus.o_busy), 32'd0);
        chk("rst_mid done", 32'(bus.o_done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst wr", 32'(bus.o_wr), 32'd0);
        chk("post_rst busy", 32'(bus.o_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
